alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational ALU between NREQ requesters (e.g. PC-increment, branch-target, execute paths of the multicycle core) using round-robin arbitration with valid/ready handshakes. It drives the ALU operand/command inputs from the granted requester and registers the ALU result into a one-entry response slot tagged with the owner. It sits between the multicycle controller's request sources and the ALU instance.

## Interface
- NREQ, 3: number of requesters, 2..8.
- WIDTH, 32: operand/result width; must equal the ALU width (32).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  request pending, per requester.
- req_ready  out  NREQ  one-hot grant/accept; handshake when req_valid[i]&req_ready[i].
- req_in1  in  NREQ*WIDTH  operand 1, requester i at bits [i*WIDTH +: WIDTH].
- req_in2  in  NREQ*WIDTH  operand 2, same packing.
- req_cmd  in  NREQ*4  ALU command, requester i at [i*4 +: 4].
- alu_in1, alu_in2  out  WIDTH  to ALU in1/in2.
- alu_cmd  out  4  to ALU cmd.
- alu_result  in  WIDTH  from ALU result.
- rsp_valid  out  NREQ  one-hot, result held for requester i.
- rsp_ready  in  NREQ  requester i accepts result.
- rsp_data  out  WIDTH  registered result.

## Operation
- State: slot_full (= |rsp_valid), rsp_owner, rsp_data, rr pointer ptr in [0,NREQ-1].
- slot_free = !slot_full | (rsp_valid[rsp_owner] & rsp_ready[rsp_owner]).
- Grant (combinational): if slot_free, pick first i with req_valid[i] searching ptr, ptr+1, ... mod NREQ; req_ready = onehot(i). Otherwise req_ready = 0.
- req_ready never asserts without req_valid on the same bit; at most one bit set.
- ALU drive: alu_in1/in2/cmd = granted requester's fields; when no grant, all zero (cmd 0000).
- On handshake at edge: rsp_data <= alu_result; rsp_valid <= onehot(i); ptr <= (i+1) mod NREQ.
- On response consume without new grant: rsp_valid <= 0; rsp_data holds its value.
- Consume and new grant same cycle: slot reloads with new owner; no bubble.
- Commands are passed unchanged; undefined codes yield ALU result 0, delivered normally. in2 passed full-width (shift amounts not masked here).
- Requester must hold req_valid and operands stable until handshake; dropping req_valid before grant is allowed (request withdrawn).

## Timing
- Reset: req_ready=0, rsp_valid=0, rsp_data=0, ptr=0, alu_* = 0.
- Request-to-response latency: 1 cycle (rsp_valid high the cycle after handshake).
- Throughput: one op per cycle when each result is consumed in the cycle it appears.
- Full slot unconsumed: req_ready=0 for all, ALU inputs zero, pointer frozen.
- ptr wraps NREQ-1 -> 0.
- Reset asserted mid-operation: held result discarded immediately; requesters reissue.

## Configuration
- ALU_ARB_LOCK_EN defined: extra input req_lock [NREQ]; if the granted requester has req_lock[i]=1 at handshake, ptr <= i (it keeps highest priority for back-to-back sequences, e.g. multi-step address calc). Lock releases on the first handshake with req_lock[i]=0.
- Undefined: no req_lock port; ptr always advances to i+1.

## Structure
- Shared package alu_pkg: ALU command constants ALU_ADD=0000, ALU_SUB=0010, ALU_AND=0100, ALU_OR=0101, ALU_NOR=0110, ALU_XOR=0111, ALU_SLL=1000, ALU_SRA=1001, ALU_SRL=1010; ALU_CMD_W=4.
- One sub-module: rr_picker (combinational: req vector + ptr -> one-hot grant + index).
- ALU itself instantiated outside; arbiter only drives/consumes its ports.

## Test plan
- Single req: req0 in1=5 in2=3 cmd=SUB, rsp_ready=1 -> req_ready[0] same cycle, next cycle rsp_valid=001, rsp_data=2.
- All three valid continuously, rsp_ready=111 -> grants 0,1,2,0,1,2 one per cycle, each rsp_data correct.
- req1 SRA in1=0x80000000 in2=4, rsp_ready[1]=0 for 3 cycles while req0 valid -> rsp_data=0xF8000000 held, req_ready=0, req0 granted cycle rsp_ready[1] rises.
- Undefined cmd 1111 from req2 -> rsp_valid=100, rsp_data=0.
- rst_n low while rsp_valid=010 -> rsp_valid=0, rsp_data=0 immediately; after release first grant goes to req0.
- ALU_ARB_LOCK_EN: req1 locked, req0/req2 valid -> req1 granted consecutively until lock dropped, then req2.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU command encodings and shared helpers for the ALU arbiter slice.
// The ALU itself lives outside the arbiter; these constants name the 4-bit
// command codes the requesters place on req_cmd.
package alu_pkg;

  localparam int ALU_CMD_W = 4;
  localparam int ALU_WIDTH = 32;

  typedef logic [ALU_CMD_W-1:0] aluCmd_t;

  localparam aluCmd_t ALU_ADD = 4'b0000;
  localparam aluCmd_t ALU_SUB = 4'b0010;
  localparam aluCmd_t ALU_AND = 4'b0100;
  localparam aluCmd_t ALU_OR  = 4'b0101;
  localparam aluCmd_t ALU_NOR = 4'b0110;
  localparam aluCmd_t ALU_XOR = 4'b0111;
  localparam aluCmd_t ALU_SLL = 4'b1000;
  localparam aluCmd_t ALU_SRA = 4'b1001;
  localparam aluCmd_t ALU_SRL = 4'b1010;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// rr_picker: purely combinational round-robin search. Starting at i_ptr and
// wrapping modulo NREQ, it returns the first asserted request as a one-hot
// grant plus its binary index. o_any is low when nothing is requested.
module rr_picker #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  // Walk the requests in priority order ptr, ptr+1, ... and latch the first hit.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int w_pos;
      w_pos = (int'(i_ptr) + k) % NREQ;
      if (!o_any && i_req[w_pos]) begin
        o_any          = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = PW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU among NREQ requesters using
// round-robin arbitration. The granted requester's operands drive the ALU in
// the same cycle; the ALU result is captured into a single response slot whose
// one-hot valid vector also identifies the owner.
// Optional feature: define ALU_ARB_LOCK_EN to add a req_lock input that lets
// the granted requester keep top priority for back-to-back operations.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_in1,
  input  logic [NREQ*WIDTH-1:0]     req_in2,
  input  logic [NREQ*ALU_CMD_W-1:0] req_cmd,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0]           req_lock,
`endif
  output logic [WIDTH-1:0]          alu_in1,
  output logic [WIDTH-1:0]          alu_in2,
  output logic [ALU_CMD_W-1:0]      alu_cmd,
  input  logic [WIDTH-1:0]          alu_result,
  output logic [NREQ-1:0]           rsp_valid,
  input  logic [NREQ-1:0]           rsp_ready,
  output logic [WIDTH-1:0]          rsp_data
);

  localparam int PW = idxWidth(NREQ);

  // The one-hot r_rspValid doubles as the owner tag, so no separate owner
  // register is kept.
  logic [NREQ-1:0]  r_rspValid;
  logic [WIDTH-1:0] r_rspData;
  logic [PW-1:0]    r_ptr;

  logic             w_slotFull;
  logic             w_consume;
  logic             w_slotFree;
  logic [NREQ-1:0]  w_reqMasked;
  logic [NREQ-1:0]  w_grant;
  logic [PW-1:0]    w_idx;
  logic             w_any;
  logic [PW-1:0]    w_nextPtr;
  logic             w_hold;

  assign w_slotFull = |r_rspValid;
  assign w_consume  = |(r_rspValid & rsp_ready);
  assign w_slotFree = !w_slotFull || w_consume;

  // Requests are only eligible when the slot can take a result, and never
  // while reset is held, so a stale request cannot see req_ready during reset.
  assign w_reqMasked = (rst_n && w_slotFree) ? req_valid : '0;

  rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_picker (
    .i_req   (w_reqMasked),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign req_ready = w_grant;
  assign w_nextPtr = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);

`ifdef ALU_ARB_LOCK_EN
  assign w_hold = |(w_grant & req_lock);
`else
  assign w_hold = 1'b0;
`endif

  // Steer the granted requester's fields to the ALU; idle inputs are zero.
  always_comb begin
    alu_in1 = '0;
    alu_in2 = '0;
    alu_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        alu_in1 = req_in1[i*WIDTH +: WIDTH];
        alu_in2 = req_in2[i*WIDTH +: WIDTH];
        alu_cmd = req_cmd[i*ALU_CMD_W +: ALU_CMD_W];
      end
    end
  end

  // Capture the result on a handshake, clear the slot when consumed without
  // a replacement, and advance (or hold, when locked) the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspValid <= '0;
      r_rspData  <= '0;
      r_ptr      <= '0;
    end else if (w_any) begin
      r_rspValid <= w_grant;
      r_rspData  <= alu_result;
      r_ptr      <= w_hold ? w_idx : w_nextPtr;
    end else if (w_consume) begin
      r_rspValid <= '0;
    end
  end

  assign rsp_valid = r_rspValid;
  assign rsp_data  = r_rspData;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with NREQ=3.
// A behavioral ALU closes the loop; expected responses are queued when a
// grant is observed and popped by a monitor when a response is consumed.
module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct packed {
    logic [2:0]  owner;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [95:0] req_in1;
  logic [95:0] req_in2;
  logic [11:0] req_cmd;
`ifdef ALU_ARB_LOCK_EN
  logic [2:0]  req_lock;
`endif
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_result;
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_ready;
  logic [31:0] rsp_data;

  int   checks = 0;
  int   errors = 0;
  rsp_t sbQ[$];
  rsp_t monE;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(3), .WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_in1    (req_in1),
    .req_in2    (req_in2),
    .req_cmd    (req_cmd),
`ifdef ALU_ARB_LOCK_EN
    .req_lock   (req_lock),
`endif
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_cmd    (alu_cmd),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data)
  );

  // Behavioral stand-in for the external ALU.
  always_comb begin
    case (alu_cmd)
      ALU_ADD: alu_result = alu_in1 + alu_in2;
      ALU_SUB: alu_result = alu_in1 - alu_in2;
      ALU_AND: alu_result = alu_in1 & alu_in2;
      ALU_OR:  alu_result = alu_in1 | alu_in2;
      ALU_NOR: alu_result = ~(alu_in1 | alu_in2);
      ALU_XOR: alu_result = alu_in1 ^ alu_in2;
      ALU_SLL: alu_result = alu_in1 << alu_in2[4:0];
      ALU_SRA: alu_result = $signed(alu_in1) >>> alu_in2[4:0];
      ALU_SRL: alu_result = alu_in1 >> alu_in2[4:0];
      default: alu_result = '0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic setReq(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c);
    req_in1[i*32 +: 32] = a;
    req_in2[i*32 +: 32] = b;
    req_cmd[i*4 +: 4]   = c;
  endtask

  task automatic pushExp(input logic [2:0] owner, input logic [31:0] data);
    rsp_t e;
    e.owner = owner;
    e.data  = data;
    sbQ.push_back(e);
  endtask

  // Drive one cycle of inputs just after the rising edge, then settle at the falling edge.
  task automatic applyStimulus(input logic [2:0] valid, input logic [2:0] rdy);
    @(posedge clk);
    #1;
    req_valid = valid;
    rsp_ready = rdy;
    @(negedge clk);
  endtask

  // Monitor: every consumed response is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && ((rsp_valid & rsp_ready) != 3'b000)) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected response: got owner %b data 0x%08h, expected none",
                 rsp_valid, rsp_data);
      end else begin
        monE = sbQ.pop_front();
        checkOutput("rsp owner", {29'd0, rsp_valid}, {29'd0, monE.owner});
        checkOutput("rsp data", rsp_data, monE.data);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  expG [6];
    logic [31:0] expD [3];

    rst_n     = 1'b0;
    req_valid = 3'b001;
    rsp_ready = 3'b000;
    req_in1   = '0;
    req_in2   = '0;
    req_cmd   = '0;
`ifdef ALU_ARB_LOCK_EN
    req_lock  = 3'b000;
`endif
    setReq(0, 32'd5, 32'd3, ALU_SUB);

    // Reset state, with a request already pending that must not be accepted.
    #2;
    checkOutput("reset req_ready", {29'd0, req_ready}, 32'd0);
    checkOutput("reset rsp_valid", {29'd0, rsp_valid}, 32'd0);
    checkOutput("reset rsp_data", rsp_data, 32'd0);
    checkOutput("reset alu_in1", alu_in1, 32'd0);
    checkOutput("reset alu_cmd", {28'd0, alu_cmd}, 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = 3'b000;

    // Single request: 5 - 3 from requester 0, granted the same cycle.
    applyStimulus(3'b001, 3'b111);
    checkOutput("single grant", {29'd0, req_ready}, 32'd1);
    checkOutput("single alu_in1", alu_in1, 32'd5);
    checkOutput("single alu_in2", alu_in2, 32'd3);
    checkOutput("single alu_cmd", {28'd0, alu_cmd}, {28'd0, ALU_SUB});
    pushExp(3'b001, 32'd2);
    applyStimulus(3'b000, 3'b111);
    checkOutput("single rsp_valid", {29'd0, rsp_valid}, 32'd1);
    checkOutput("idle req_ready", {29'd0, req_ready}, 32'd0);

    // All three valid continuously; pointer is at 1 after the single request.
    setReq(0, 32'd10, 32'd20, ALU_ADD);
    setReq(1, 32'hFF00FF00, 32'h0F0F0F0F, ALU_XOR);
    setReq(2, 32'd1, 32'd4, ALU_SLL);
    expD[0] = 32'd30;
    expD[1] = 32'hF00FF00F;
    expD[2] = 32'd16;
    expG    = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(3'b111, 3'b111);
      checkOutput("rr grant", {29'd0, req_ready}, {29'd0, expG[i]});
      case (expG[i])
        3'b001:  pushExp(3'b001, expD[0]);
        3'b010:  pushExp(3'b010, expD[1]);
        default: pushExp(3'b100, expD[2]);
      endcase
    end

    // Held result: requester 1 SRA, its consumer stalls three cycles.
    setReq(1, 32'h80000000, 32'd4, ALU_SRA);
    applyStimulus(3'b010, 3'b101);
    checkOutput("hold grant", {29'd0, req_ready}, 32'd2);
    pushExp(3'b010, 32'hF8000000);
    setReq(0, 32'd7, 32'd8, ALU_ADD);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b001, 3'b101);
      checkOutput("full req_ready", {29'd0, req_ready}, 32'd0);
      checkOutput("full rsp_valid", {29'd0, rsp_valid}, 32'd2);
      checkOutput("full rsp_data", rsp_data, 32'hF8000000);
      checkOutput("full alu_in1", alu_in1, 32'd0);
    end
    applyStimulus(3'b001, 3'b111);
    checkOutput("release grant", {29'd0, req_ready}, 32'd1);
    checkOutput("release alu_in1", alu_in1, 32'd7);
    pushExp(3'b001, 32'd15);
    applyStimulus(3'b000, 3'b111);

    // Undefined command from requester 2 returns zero.
    setReq(2, 32'd123, 32'd456, 4'b1111);
    applyStimulus(3'b100, 3'b111);
    checkOutput("undef grant", {29'd0, req_ready}, 32'd4);
    checkOutput("undef alu_cmd", {28'd0, alu_cmd}, 32'd15);
    pushExp(3'b100, 32'd0);
    applyStimulus(3'b000, 3'b111);

    // Reset while requester 1 holds an unconsumed result.
    setReq(1, 32'd1, 32'd1, ALU_ADD);
    applyStimulus(3'b010, 3'b000);
    checkOutput("pre-reset grant", {29'd0, req_ready}, 32'd2);
    applyStimulus(3'b000, 3'b000);
    checkOutput("pre-reset rsp_valid", {29'd0, rsp_valid}, 32'd2);
    checkOutput("pre-reset rsp_data", rsp_data, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset rsp_valid", {29'd0, rsp_valid}, 32'd0);
    checkOutput("async reset rsp_data", rsp_data, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    setReq(0, 32'h0000F0F0, 32'h00000FF0, ALU_AND);
    setReq(2, 32'd5, 32'd5, ALU_ADD);
    applyStimulus(3'b111, 3'b111);
    checkOutput("post-reset grant", {29'd0, req_ready}, 32'd1);
    pushExp(3'b001, 32'h000000F0);
    applyStimulus(3'b000, 3'b111);

`ifdef ALU_ARB_LOCK_EN
    // Requester 1 locked keeps the grant; after unlocking, requester 2 follows.
    setReq(2, 32'd9, 32'd4, ALU_SUB);
    req_lock = 3'b010;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b111, 3'b111);
      checkOutput("locked grant", {29'd0, req_ready}, 32'd2);
      pushExp(3'b010, 32'd2);
    end
    @(posedge clk);
    #1;
    req_lock  = 3'b000;
    req_valid = 3'b111;
    @(negedge clk);
    checkOutput("unlock grant", {29'd0, req_ready}, 32'd2);
    pushExp(3'b010, 32'd2);
    applyStimulus(3'b111, 3'b111);
    checkOutput("after unlock grant", {29'd0, req_ready}, 32'd4);
    pushExp(3'b100, 32'd5);
    applyStimulus(3'b000, 3'b111);
`endif

    applyStimulus(3'b000, 3'b111);
    applyStimulus(3'b000, 3'b111);
    checkOutput("scoreboard drained", sbQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
